// File: rtl/apb_requester.sv
// APB requester: a small command FIFO feeding an IDLE/SETUP/ACCESS transfer FSM.
// Each accepted command produces exactly one response; a stalled ACCESS is aborted after TIMEOUT cycles.
module apb_requester #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int DEPTH   = 4
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     head;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              push, pop;
  logic [7:0]        wcnt, wcnt_d;
  logic              psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;

  // Full means full: a same-cycle pop never frees a slot for a push.
  assign cmd_ready  = (count < FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  assign busy       = (state != IDLE) || (count != '0);
  assign head       = mem[rd_ptr];
  assign head_write = head[EW-1];
  assign head_addr  = head[DATA_W +: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    wcnt_d      = wcnt;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          pwrite_d  = head_write;
          paddr_d   = head_addr;
          pwdata_d  = head_write ? head_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wcnt_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A ready completer wins even on the last allowed wait cycle.
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite ? '0 : prdata;
          state_d     = IDLE;
        end else if (wcnt == TMO_LAST) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end else begin
          wcnt_d = wcnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wcnt      <= '0;
    end else begin
      state     <= state_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      wcnt      <= wcnt_d;
    end
  end

endmodule
